// File: rtl/pool_line_buffer.sv
// Line buffer that feeds a 2x2 max-pooling stage. It stores one row, and on odd rows it
// emits each vertical pixel pair (even column, then odd column) on two back-to-back cycles.
module pool_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 24,
  parameter int IMG_HEIGHT = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] line_1,
  output logic [DATA_WIDTH-1:0] line_2,
  output logic                  pair_valid,
  output logic                  pool_valid,
  output logic                  frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, EMIT0, EMIT1} emit_state_e;

  emit_state_e state, state_nxt;

  logic [COL_W-1:0]      col_q, col_cur;
  logic [ROW_W-1:0]      row_q, row_cur;
  logic                  last_col, last_row;
  logic                  even_capture, odd_accept, sof_accept;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] hold_1, hold_2;
  logic [DATA_WIDTH-1:0] emit_1, emit_2;
  logic [DATA_WIDTH-1:0] line_1_nxt, line_2_nxt;
  logic                  pair_valid_nxt;
  logic                  pool_d1;

  logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];

  // A start-of-frame pixel is always (0,0), whatever the counters say.
  always_comb begin
    col_cur      = in_sof ? '0 : col_q;
    row_cur      = in_sof ? '0 : row_q;
    last_col     = (col_cur == COL_W'(IMG_WIDTH - 1));
    last_row     = (row_cur == ROW_W'(IMG_HEIGHT - 1));
    sof_accept   = in_valid & in_sof;
    even_capture = in_valid & row_cur[0] & ~col_cur[0];
    odd_accept   = in_valid & row_cur[0] & col_cur[0];
    rd_data      = mem[col_cur];
  end

  // NOTE: the row store has no reset; every entry is written before it is read in a frame.
  always_ff @(posedge clk) begin
    if (in_valid) mem[col_cur] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so that the read of mem above and
  // every register below see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_valid & last_col & last_row;
      if (in_valid) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_cur + 1'b1;
        end else begin
          col_q <= col_cur + 1'b1;
          row_q <= row_cur;
        end
      end
    end
  end

  // The odd-column pair gets its own register so a new even-column capture into hold_*
  // during EMIT0/EMIT1 cannot disturb the pair still being emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_1 <= '0;
      hold_2 <= '0;
      emit_1 <= '0;
      emit_2 <= '0;
    end else begin
      if (even_capture) begin
        hold_1 <= rd_data;
        hold_2 <= in_data;
      end
      if (odd_accept) begin
        emit_1 <= rd_data;
        emit_2 <= in_data;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt      = state;
    line_1_nxt     = line_1;
    line_2_nxt     = line_2;
    pair_valid_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (odd_accept) begin
          state_nxt      = EMIT0;
          line_1_nxt     = hold_1;
          line_2_nxt     = hold_2;
          pair_valid_nxt = 1'b1;
        end
      end
      EMIT0: begin
        state_nxt      = EMIT1;
        line_1_nxt     = emit_1;
        line_2_nxt     = emit_2;
        pair_valid_nxt = 1'b1;
      end
      EMIT1: begin
        if (odd_accept) begin
          state_nxt      = EMIT0;
          line_1_nxt     = hold_1;
          line_2_nxt     = hold_2;
          pair_valid_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (sof_accept) begin
      state_nxt      = IDLE;
      line_1_nxt     = line_1;
      line_2_nxt     = line_2;
      pair_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      line_1     <= '0;
      line_2     <= '0;
      pair_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      line_1     <= line_1_nxt;
      line_2     <= line_2_nxt;
      pair_valid <= pair_valid_nxt;
    end
  end

  // Two stages match the pooling stage's input and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_d1    <= 1'b0;
      pool_valid <= 1'b0;
    end else begin
      pool_d1    <= (state == EMIT1);
      pool_valid <= pool_d1;
    end
  end

endmodule

// File: doc/pool_line_buffer.md
Name: pool_line_buffer

Overview:
- Upstream feeder for the 2x2 max-pooling stage.
- Accepts a raster-scan pixel stream (conv/ReLU output) with a valid strobe and stores one full row.
- On odd rows it presents vertically aligned pixel pairs as line_1 (row r-1) and line_2 (row r) on two consecutive cycles per column pair (even column, then odd column), as the pooling stage requires.
- It also generates a strobe aligned to the pooling stage's registered max output.

Parameters:
- DATA_WIDTH, 8: pixel width in bits.
- IMG_WIDTH, 24: pixels per row. Must be even and at least 2.
- IMG_HEIGHT, 24: rows per frame. Must be even and at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data valid this cycle.
- in_sof  input  1  start of frame. Sampled only with in_valid; marks pixel (row 0, col 0).
- in_data  input  DATA_WIDTH  input pixel.
- line_1  output  DATA_WIDTH  pixel from previous row, same column. Registered.
- line_2  output  DATA_WIDTH  pixel from current row. Registered.
- pair_valid  output  1  line_1/line_2 carry a valid vertical pair this cycle.
- pool_valid  output  1  downstream 2x2 max output is valid this cycle.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async, rst_n low): line_1, line_2, pair_valid, pool_valid and frame_done go to 0. Column/row counters, hold register and emit FSM are cleared. Line-buffer storage is not reset.
- Counters advance only on in_valid: col counts 0..IMG_WIDTH-1; row increments on col wrap and counts 0..IMG_HEIGHT-1, then wraps to 0.
- in_sof with in_valid forces the pixel to (0,0), whatever the counter state. Any partial pair or emit in progress is discarded and the emit FSM returns to IDLE.
- Line buffer, IMG_WIDTH deep:
  - Every accepted pixel is written at index col.
  - On odd rows, the old entry at index col is read first (read-before-write, same cycle).
- Even rows: pixels are written only. No pair output, no pool_valid.
- Odd row, even col: capture {buf[col], in_data} into the hold register.
- Odd row, odd col: capture {buf[col], in_data} into the second slot and start emission.
- Emit FSM:
  - IDLE: on an odd-row, odd-col accept, go to EMIT0.
  - EMIT0 (1 cycle): line_1/line_2 = even-col pair, pair_valid = 1. Next state EMIT1.
  - EMIT1 (1 cycle): line_1/line_2 = odd-col pair, pair_valid = 1. Next state IDLE.
    - If another odd-col accept occurs in this cycle, go directly to EMIT0.
  - Registered outputs: the even pair appears the cycle after the odd-col pixel is accepted; the odd pair appears the cycle after that.
- Input gaps are allowed anywhere. Emission is always exactly two back-to-back cycles per column pair, independent of input gaps.
- Back-to-back input cannot overlap emissions, because odd-col accepts are at least 2 cycles apart. Hold-register writes during EMIT0/EMIT1 must not corrupt the pair being emitted, so use a separate emit register pair.
- line_1/line_2 hold their last values when pair_valid = 0.
- pool_valid: asserted exactly 2 cycles after an EMIT1 cycle, matching the pooling stage's input and output register pipeline.
  - Example: EMIT1 at cycle t, pool_valid = 1 at cycle t+2.
- Per frame: IMG_WIDTH/2 x IMG_HEIGHT/2 pool_valid pulses.
- frame_done pulses the cycle after the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Reset mid-frame clears all state. The next frame must begin with in_sof or at counter state (0,0).

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, continuous valid:
  - Stimulus: row0 = 1,2,3,4; row1 = 5,6,7,8.
  - Required: pairs (1,5),(2,6) on consecutive cycles, then (3,7),(4,8).
  - Downstream pooling sees 6 and 8.
  - 2 pool_valid pulses, each 2 cycles after its EMIT1. One frame_done.
- Same image with in_valid toggling 1,0,1,0,…: identical pair sequence; each pair is still emitted on 2 back-to-back cycles.
- Default 24x24 ramp image (pixel = row*24+col mod 256), continuous valid: exactly 144 pool_valid pulses. Each pooled max equals pixel (2i+1, 2j+1) mod-256 where no wrap occurs.
- in_sof asserted at row 1, col 1 mid-frame: partial state discarded; no spurious pair_valid; subsequent frame output correct.
- rst_n low for 2 cycles during EMIT0: all outputs 0 immediately (async); no pool_valid afterward; next frame correct.
- Even-row-only stimulus (12 pixels of a 24-wide frame): pair_valid and pool_valid stay 0 throughout.
